// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: address map, RAM depth,
// access-size encodings and STATUS bit positions.
package dmem_pkg;

  localparam int RAM_DEPTH = 256;
  localparam int RAM_AW    = $clog2(RAM_DEPTH);

  localparam logic [31:0] RAM_LIMIT   = 32'h0000_03FF;
  localparam logic [31:0] GPIO_ADDR   = 32'h0000_1000;
  localparam logic [31:0] TCOUNT_ADDR = 32'h0000_1004;
  localparam logic [31:0] TCMP_ADDR   = 32'h0000_1008;
  localparam logic [31:0] STATUS_ADDR = 32'h0000_100C;

  localparam int ST_MISALIGN = 0;
  localparam int ST_MATCH    = 1;
  localparam int ST_UNMAPPED = 2;
  localparam int ST_W        = 3;

  // Load encodings; stores reuse the low two bits (SB/SH/SW = LB/LH/LW).
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_e;

endpackage

// File: rtl/dmem_timer.sv
// Free-running 32-bit timer with compare register; raises match while
// TCOUNT equals a non-zero TCMP.
module dmem_timer
(
  input  logic        CLOCK,
  input  logic        RST_n,
  input  logic        wr_cnt,
  input  logic        wr_cmp,
  input  logic [31:0] wdata,
  output logic [31:0] tcount,
  output logic [31:0] tcmp,
  output logic        match
);

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      tcount <= 32'h0;
      tcmp   <= 32'h0;
    end else begin
      tcount <= wr_cnt ? wdata : tcount + 32'd1;
      if (wr_cmp) tcmp <= wdata;
    end
  end

  assign match = (tcount == tcmp) && (tcmp != 32'h0);

endmodule

// File: rtl/dmem_responder.sv
// Single-cycle data memory + peripheral responder for the core's load/store
// path. Timer support is built only when DMEM_TIMER_EN is defined.
module dmem_responder
  import dmem_pkg::*;
(
  input  logic        CLOCK,
  input  logic        RST_n,
  input  logic        ena_wr,
  input  logic        ena_rd,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic [31:0] gpio_out,
  output logic        irq_timer
);

  logic [31:0]       mem [RAM_DEPTH];
  logic [31:0]       gpio_q;
  logic [ST_W-1:0]   status_q, status_d;
  logic [31:0]       tcount, tcmp;
  logic              match_evt;

  logic [31:0]       word_addr;
  logic [RAM_AW-1:0] ram_idx;
  logic is_ram, is_gpio, is_tcnt, is_tcmp, is_stat, is_periph, mapped, access;
  logic sub_word, f3_bad, size_bad, misalign, ok, reg_wr, ram_we;
  logic [3:0]        be;
  logic [31:0]       wlane, rword;
  logic [15:0]       hsel;
  logic [7:0]        bsel;

  assign word_addr = {addr[31:2], 2'b00};
  assign ram_idx   = addr[RAM_AW+1:2];
  assign is_ram    = addr <= RAM_LIMIT;
  assign is_gpio   = word_addr == GPIO_ADDR;
  assign is_tcnt   = word_addr == TCOUNT_ADDR;
  assign is_tcmp   = word_addr == TCMP_ADDR;
  assign is_stat   = word_addr == STATUS_ADDR;
  assign is_periph = is_gpio | is_tcnt | is_tcmp | is_stat;
  assign mapped    = is_ram | is_periph;
  assign access    = ena_wr | ena_rd;

  // Size decode, byte enables and lane-replicated store data.
  always_comb begin
    sub_word = 1'b0;
    f3_bad   = 1'b0;
    size_bad = 1'b0;
    be       = 4'b0000;
    wlane    = wdata;
    case (funct3_e'(funct3))
      F3_LB, F3_LBU: begin
        sub_word = 1'b1;
        be       = 4'b0001 << addr[1:0];
        wlane    = {4{wdata[7:0]}};
      end
      F3_LH, F3_LHU: begin
        sub_word = 1'b1;
        size_bad = addr[0];
        be       = addr[1] ? 4'b1100 : 4'b0011;
        wlane    = {2{wdata[15:0]}};
      end
      F3_LW: begin
        size_bad = |addr[1:0];
        be       = 4'b1111;
      end
      default: f3_bad = 1'b1;
    endcase
  end

  // Peripheral registers only accept full-word accesses.
  assign misalign = f3_bad | size_bad | (is_periph & sub_word);
  assign ok       = mapped & ~misalign;
  assign reg_wr   = ena_wr & ok;
  // RST_n gating drops a store that lands while reset is held.
  assign ram_we   = reg_wr & is_ram & RST_n;

  always_ff @(posedge CLOCK) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[ram_idx][8*i +: 8] <= wlane[8*i +: 8];
    end
  end

`ifdef DMEM_TIMER_EN
  dmem_timer u_timer (
    .CLOCK  (CLOCK),
    .RST_n  (RST_n),
    .wr_cnt (reg_wr & is_tcnt),
    .wr_cmp (reg_wr & is_tcmp),
    .wdata  (wdata),
    .tcount (tcount),
    .tcmp   (tcmp),
    .match  (match_evt)
  );
`else
  assign tcount    = 32'h0;
  assign tcmp      = 32'h0;
  assign match_evt = 1'b0;
`endif

  // Set events take priority over a same-cycle write-1-to-clear.
  always_comb begin
    status_d = status_q;
    if (reg_wr && is_stat) status_d = status_q & ~wdata[ST_W-1:0];
    if (access && mapped && misalign) status_d[ST_MISALIGN] = 1'b1;
    if (access && !mapped)            status_d[ST_UNMAPPED] = 1'b1;
    if (match_evt)                    status_d[ST_MATCH]    = 1'b1;
  end

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      gpio_q   <= 32'h0;
      status_q <= '0;
    end else begin
      if (reg_wr && is_gpio) gpio_q <= wdata;
      status_q <= status_d;
    end
  end

  always_comb begin
    rword = 32'h0;
    if (is_ram)       rword = mem[ram_idx];
    else if (is_gpio) rword = gpio_q;
    else if (is_tcnt) rword = tcount;
    else if (is_tcmp) rword = tcmp;
    else if (is_stat) rword = {{(32-ST_W){1'b0}}, status_q};

    hsel = addr[1] ? rword[31:16] : rword[15:0];
    case (addr[1:0])
      2'd0:    bsel = rword[7:0];
      2'd1:    bsel = rword[15:8];
      2'd2:    bsel = rword[23:16];
      default: bsel = rword[31:24];
    endcase

    case (funct3_e'(funct3))
      F3_LB:   rdata = {{24{bsel[7]}}, bsel};
      F3_LH:   rdata = {{16{hsel[15]}}, hsel};
      F3_LW:   rdata = rword;
      F3_LBU:  rdata = {24'h0, bsel};
      F3_LHU:  rdata = {16'h0, hsel};
      default: rdata = 32'h0;
    endcase
    if (!(ena_rd && ok)) rdata = 32'h0;
  end

  assign gpio_out  = gpio_q;
  assign irq_timer = status_q[ST_MATCH];

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-addressed reference model,
// directed scenarios followed by randomized traffic.
module tb_dmem_responder;

  logic        CLOCK = 1'b0;
  logic        RST_n = 1'b0;
  logic        ena_wr = 1'b0, ena_rd = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] rdata, gpio_out;
  logic        irq_timer;

  dmem_responder dut (
    .CLOCK     (CLOCK),
    .RST_n     (RST_n),
    .ena_wr    (ena_wr),
    .ena_rd    (ena_rd),
    .addr      (addr),
    .wdata     (wdata),
    .funct3    (funct3),
    .rdata     (rdata),
    .gpio_out  (gpio_out),
    .irq_timer (irq_timer)
  );

  always #5 CLOCK = ~CLOCK;

`ifdef DMEM_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  // Reference state
  byte unsigned m_ram [1024];
  logic [31:0]  m_gpio, m_tcnt, m_tcmp;
  bit           m_mis, m_match, m_unm;

  // Scoreboard queues (one entry per driven cycle)
  string       nm_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] gp_q[$];
  bit          irq_q[$];
  int checks = 0;
  int errors = 0;

  function automatic int acc_size(input logic [2:0] f);
    if (f == 3'b011 || f == 3'b110 || f == 3'b111) return 0;
    return 1 << f[1:0];
  endfunction

  function automatic bit is_periph(input logic [31:0] a);
    return a >= 32'h1000 && a <= 32'h100F;
  endfunction

  function automatic bit is_mapped(input logic [31:0] a);
    return a <= 32'h3FF || is_periph(a);
  endfunction

  function automatic bit is_mis(input logic [31:0] a, input logic [2:0] f);
    int sz = acc_size(f);
    if (sz == 0) return 1'b1;
    if (a % sz != 0) return 1'b1;
    return is_periph(a) && sz != 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] f);
    int sz;
    logic [31:0] v;
    if (!is_mapped(a) || is_mis(a, f)) return 32'h0;
    sz = acc_size(f);
    v = 32'h0;
    if (is_periph(a)) begin
      case (a & ~32'h3)
        32'h1000: v = m_gpio;
        32'h1004: v = m_tcnt;
        32'h1008: v = m_tcmp;
        default:  v = {29'h0, m_unm, m_match, m_mis};
      endcase
    end else begin
      for (int i = 0; i < sz; i++) v = v | (32'(m_ram[a + i]) << (8 * i));
      if (!f[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    end
    return v;
  endfunction

  task automatic m_reset();
    m_gpio = 0; m_tcnt = 0; m_tcmp = 0;
    m_mis = 0; m_match = 0; m_unm = 0;
  endtask

  task automatic m_step(input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f);
    bit mt;
    logic [31:0] nxt;
    mt  = TIMER && m_tcnt == m_tcmp && m_tcmp != 0;
    nxt = TIMER ? m_tcnt + 32'd1 : 32'h0;
    if ((w || r) && !is_mapped(a)) m_unm = 1'b1;
    else if ((w || r) && is_mis(a, f)) m_mis = 1'b1;
    else if (w) begin
      if (!is_periph(a)) begin
        for (int i = 0; i < acc_size(f); i++) m_ram[a + i] = d[8*i +: 8];
      end else begin
        case (a & ~32'h3)
          32'h1000: m_gpio = d;
          32'h1004: if (TIMER) nxt = d;
          32'h1008: if (TIMER) m_tcmp = d;
          default: begin
            if (d[0]) m_mis = 1'b0;
            if (d[1]) m_match = 1'b0;
            if (d[2]) m_unm = 1'b0;
          end
        endcase
      end
    end
    if (mt) m_match = 1'b1;
    m_tcnt = nxt;
  endtask

  task automatic check(input string nm, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, what, act, exp);
    end
  endtask

  // One core cycle: inputs applied just after the rising edge, expectation
  // queued, model advanced at the next rising edge.
  task automatic cyc(input string nm, input bit w, input bit r,
                     input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                     input bit rst_mid = 1'b0, input bit use_lit = 1'b0,
                     input logic [31:0] lit = 32'h0);
    ena_wr = w; ena_rd = r; addr = a; wdata = d; funct3 = f;
    if (rst_mid) begin
      #2;
      RST_n = 1'b0;
      m_reset();
    end
    nm_q.push_back(nm);
    rd_q.push_back(use_lit ? lit : (r ? m_load(a, f) : 32'h0));
    gp_q.push_back(m_gpio);
    irq_q.push_back(m_match);
    @(posedge CLOCK);
    if (RST_n) m_step(w, r, a, d, f);
    #1;
    RST_n = 1'b1;
  endtask

  initial begin : monitor
    string nm;
    forever begin
      @(negedge CLOCK);
      if (rd_q.size() > 0) begin
        nm = nm_q.pop_front();
        check(nm, "rdata", rdata, rd_q.pop_front());
        check(nm, "gpio_out", gpio_out, gp_q.pop_front());
        check(nm, "irq_timer", 32'(irq_timer), 32'(irq_q.pop_front()));
      end
    end
  end

  initial begin : driver
    logic [31:0] a, d;
    logic [2:0]  f;
    int sel, sz;
    m_reset();
    @(posedge CLOCK);
    #1;
    RST_n = 1'b1;

    cyc("rst_tcount", 0, 1, 32'h1004, 0, 3'b010, 0, 1, 32'h0);
    cyc("rst_status", 0, 1, 32'h100C, 0, 3'b010, 0, 1, 32'h0);
    for (int i = 0; i < 256; i++) cyc("init", 1, 0, 32'(i * 4), $urandom, 3'b010);

    // sign/zero extension
    cyc("sw10",  1, 0, 32'h10, 32'h80FF7F01, 3'b010);
    cyc("lb13",  0, 1, 32'h13, 0, 3'b000, 0, 1, 32'hFFFFFF80);
    cyc("lbu13", 0, 1, 32'h13, 0, 3'b100, 0, 1, 32'h00000080);
    cyc("lh12",  0, 1, 32'h12, 0, 3'b001, 0, 1, 32'hFFFF80FF);
    cyc("lhu12", 0, 1, 32'h12, 0, 3'b101, 0, 1, 32'h000080FF);

    // byte lane isolation
    cyc("sw20", 1, 0, 32'h20, 32'h11223344, 3'b010);
    cyc("sb21", 1, 0, 32'h21, 32'h000000AA, 3'b000);
    cyc("lw20", 0, 1, 32'h20, 0, 3'b010, 0, 1, 32'h1122AA44);

    // misaligned store suppressed, W1C
    cyc("sw22_mis", 1, 0, 32'h22, 32'hDEADBEEF, 3'b010);
    cyc("lw20_keep", 0, 1, 32'h20, 0, 3'b010, 0, 1, 32'h1122AA44);
    cyc("st_mis",    0, 1, 32'h100C, 0, 3'b010, 0, 1, 32'h1);
    cyc("w1c_mis",   1, 0, 32'h100C, 32'h1, 3'b010);
    cyc("st_clr",    0, 1, 32'h100C, 0, 3'b010, 0, 1, 32'h0);

    // unmapped access, TCOUNT wrap
    cyc("lw_unm",  0, 1, 32'h2000, 0, 3'b010, 0, 1, 32'h0);
    cyc("st_unm",  0, 1, 32'h100C, 0, 3'b010, 0, 1, 32'h4);
    cyc("w1c_unm", 1, 0, 32'h100C, 32'h4, 3'b010);
    cyc("tc_max",  1, 0, 32'h1004, 32'hFFFFFFFF, 3'b010);
    cyc("tc_rdmx", 0, 1, 32'h1004, 0, 3'b010, 0, TIMER, 32'hFFFFFFFF);
    cyc("tc_wrap", 0, 1, 32'h1004, 0, 3'b010, 0, TIMER, 32'h0);

    // timer match with W1C on the match cycle
    cyc("tc_zero", 1, 0, 32'h1004, 32'h0, 3'b010);
    cyc("tcmp5",   1, 0, 32'h1008, 32'h5, 3'b010);
    for (int i = 1; i <= 4; i++) cyc("tc_run", 0, 1, 32'h1004, 0, 3'b010, 0, TIMER, 32'(i));
    cyc("w1c_on_match", 1, 1, 32'h100C, 32'h2, 3'b010, 0, 1, 32'h0);
    cyc("st_match",     0, 1, 32'h100C, 0, 3'b010, 0, 1, TIMER ? 32'h2 : 32'h0);
    cyc("w1c_match",    1, 0, 32'h100C, 32'h2, 3'b010);
    cyc("st_match_clr", 0, 1, 32'h100C, 0, 3'b010, 0, 1, 32'h0);

    // reset mid-operation with a store in flight
    cyc("gpio_wr", 1, 0, 32'h1000, 32'hA5A5A5A5, 3'b010);
    cyc("gpio_rd", 0, 1, 32'h1000, 0, 3'b010, 0, 1, 32'hA5A5A5A5);
    cyc("rst_tc",  0, 1, 32'h1004, 0, 3'b010, 1, 1, 32'h0);
    cyc("rst_sw",  1, 0, 32'h10, 32'hFFFFFFFF, 3'b010, 1);
    cyc("ram_kept", 0, 1, 32'h10, 0, 3'b010, 0, 1, 32'h80FF7F01);
    cyc("tc_resume", 0, 1, 32'h1004, 0, 3'b010, 0, TIMER, 32'h1);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      sel = $urandom_range(0, 9);
      f = 3'($urandom_range(0, 7));
      if (sel < 6)      a = 32'($urandom_range(0, 1023));
      else if (sel < 8) a = 32'h1000 + 32'($urandom_range(0, 15));
      else if (sel < 9) a = 32'($urandom_range(32'h400, 32'hFFF));
      else              a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        f = (sel >= 6 && sel < 8) ? 3'b010 : f;
        sz = acc_size(f);
        if (sz != 0) a = a & ~32'(sz - 1);
      end
      d = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
      cyc("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d, f,
          $urandom_range(0, 299) == 0);
    end

    ena_wr = 0; ena_rd = 0;
    repeat (3) @(posedge CLOCK);
    checks++;
    if (rd_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", rd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
